ps2_kbd_rx: RTL and testbench
=============================

# ps2_kbd_rx

Parametrised PS/2 keyboard receiver with scan-code decoding and an event FIFO. It sits between the PS/2 pins and consumers such as the keyboard display and CPU MMIO. It frames 11-bit PS/2 packets, checks parity, stop bit and inter-bit timeout, and merges `E0`/`F0` prefixes into single key events. Events are buffered in a first-word-fall-through FIFO with a valid/ready pop handshake.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of 2, minimum 2.
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth on `ps2_clk` and `ps2_data`; minimum 2.
- `TIMEOUT_CYCLES`, default 5000: maximum `clk` cycles allowed between two PS/2 falling edges inside a frame.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock pin.
- `ps2_data` input 1: raw PS/2 data pin.
- `evt_data` output 10: FIFO head as `{ext, brk, code[7:0]}`.
- `evt_valid` output 1: FIFO not empty.
- `evt_ready` input 1: consumer pops the head when `evt_valid && evt_ready`.
- `fill` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` output 1: sticky. Set when an event is dropped because the FIFO is full.
- `ovf_clr` input 1: one-cycle pulse that clears `overflow`.
- `frame_err` output 1: one-cycle pulse for a parity, start, stop or timeout error.
- `err_cnt` output 8: saturating count of `frame_err` pulses.

## Operation
- **Synchroniser:** `ps2_clk` and `ps2_data` pass through `SYNC_STAGES` flip-flops. `fall` is high for one cycle when the synchronised clock goes from 1 (previous cycle) to 0 (current cycle). Data is sampled from the synchronised `ps2_data` in the `fall` cycle.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear bit count. On `fall` with data=1, stay in IDLE and raise `frame_err`.
  - DATA: shift 8 bits LSB first. After the 8th `fall`, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on `fall`, the frame is valid when stop=1 and data^parity has odd parity. Valid: pass the byte to the decoder. Invalid: raise `frame_err`. Both cases return to IDLE.
- **Timeout:** in any non-IDLE state, a counter increments every cycle and resets on `fall`. When it reaches `TIMEOUT_CYCLES`, raise `frame_err`, discard the partial frame, go to IDLE. Timeout leaves the prefix flags unchanged.
- **Decoder:** holds `ext_pend` and `brk_pend`, both 0 at reset.
  - Byte `E0`: set `ext_pend`.
  - Byte `F0`: set `brk_pend`.
  - Any other byte: push `{ext_pend, brk_pend, byte}` and clear both flags.
  - The `E0 F0 xx` sequence yields ext=1, brk=1. A repeated `F0` while `brk_pend` is set is idempotent.
- **FIFO:** write and read pointers carry $clog2(FIFO_DEPTH) bits and wrap modulo depth.
  - `evt_data` shows the head combinationally from the storage array. It is don't-care while empty.
  - Push when full with no pop in the same cycle: drop the event, set `overflow`.
  - Push and pop in the same cycle while full: accept both; `fill` is unchanged.
  - Push and pop in the same cycle while empty: not possible, since `evt_valid`=0.
  - Pop while empty: ignored.
- **`overflow`:** if a set event and `ovf_clr` occur in the same cycle, set wins.
- **`err_cnt`:** saturates at 255.
- **Reset:** asynchronous and effective immediately, including mid-frame.
  - FSM returns to IDLE; pointers, `fill`, prefix flags, `overflow`, `err_cnt` and the timeout counter are cleared.
  - Synchronisers reset to 1 (idle-high lines).
  - Outputs: `evt_valid`=0, `fill`=0, `overflow`=0, `frame_err`=0, `err_cnt`=0, `evt_data`=don't-care.
  - Any partial frame in progress at reset is discarded.

## Timing
- `fall` is asserted SYNC_STAGES+1 cycles after a pin falling edge that meets setup time.
- Let the stop-bit `fall` cycle be N. The FIFO is written at the end of N; `evt_valid` and `fill` update in N+1.
- `frame_err` is registered and high in cycle N+1, with `err_cnt` incremented the same cycle.
- A pop at the end of cycle M updates `evt_data`, `fill` and `evt_valid` in M+1.
- Back-to-back events must be accepted at the PS/2 frame rate with no dead cycles.
- The block must sustain one push and one pop per cycle.

## Test plan
- **Make code:** send `1C`, hold `evt_ready`=0. Expect `evt_valid`=1, `evt_data`=`0_0_1C`, `fill`=1. Pop, then expect `fill`=0.
- **Break and extended sequences:** send `F0 1C`, then `E0 75`, then `E0 F0 75`. Expect events `0_1_1C`, `1_0_75`, `1_1_75`, and no events for the prefix bytes.
- **Overflow (FIFO_DEPTH=4):** send 5 make codes with `evt_ready`=0. Expect `fill`=4 and `overflow`=1, with the 5th code dropped. Pulse `ovf_clr`; expect `overflow`=0 and the first 4 codes popped in order.
- **Parity error:** send `1B` with the wrong parity bit. Expect one `frame_err` pulse, `err_cnt`=1 and no event. The next good `1B` yields `0_0_1B`.
- **Timeout:** stop the PS/2 clock after 4 data bits for more than `TIMEOUT_CYCLES`. Expect `frame_err` and the FSM back in IDLE. The next full frame `1C` decodes correctly.
- **Reset mid-frame:** assert `rst` during DATA with 2 events queued. Expect `fill`=0, `evt_valid`=0, `err_cnt`=0 immediately. A following `1C` frame decodes as `0_0_1C`.

Source files
------------

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - key event stream and status bundle of the PS/2 keyboard receiver
interface ps2_kbd_rx_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [9:0]                    evt_data;
  logic                          evt_valid;
  logic                          evt_ready;
  logic [$clog2(FIFO_DEPTH):0]   fill;
  logic                          overflow;
  logic                          ovf_clr;
  logic                          frame_err;
  logic [7:0]                    err_cnt;

  modport master (
    output evt_data, evt_valid, fill, overflow, frame_err, err_cnt,
    input  evt_ready, ovf_clr
  );

  modport slave (
    input  evt_data, evt_valid, fill, overflow, frame_err, err_cnt,
    output evt_ready, ovf_clr
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: frame checking, E0/F0 prefix merging, FWFT event FIFO
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_kbd_rx_if.master  evt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   clk_s, dat_s, fall;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   byte_ok, err_set, timeout;

  logic                   ext_pend, brk_pend;
  logic                   is_e0, is_f0, push;
  logic [9:0]             push_word;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [FW-1:0]          fill_q;
  logic                   full, pop, wr_en, drop;
  logic                   overflow_q, frame_err_q;
  logic [7:0]             err_cnt_q;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  // Lines idle high, so synchronisers reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    byte_ok   = 1'b0;
    err_set   = 1'b0;
    timeout   = (state_q != S_IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    if (state_q != S_IDLE && !fall)
      to_cnt_d = to_cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (fall) begin
        if (!dat_s) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end else begin
          err_set = 1'b1;
        end
      end
      S_DATA: if (fall) begin
        shreg_d   = {dat_s, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7)
          state_d = S_PARITY;
      end
      S_PARITY: if (fall) begin
        par_d   = dat_s;
        state_d = S_STOP;
      end
      S_STOP: if (fall) begin
        if (dat_s && (^{shreg_q, par_q}))
          byte_ok = 1'b1;
        else
          err_set = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d  = S_IDLE;
      err_set  = 1'b1;
      to_cnt_d = '0;
    end
  end

  assign is_e0     = (shreg_q == 8'hE0);
  assign is_f0     = (shreg_q == 8'hF0);
  assign push      = byte_ok && !is_e0 && !is_f0;
  assign push_word = {ext_pend, brk_pend, shreg_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_ok) begin
      if (is_e0) begin
        ext_pend <= 1'b1;
      end else if (is_f0) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  assign full  = (fill_q == FW'(FIFO_DEPTH));
  assign pop   = (fill_q != '0) && evt.evt_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        fill_q <= fill_q + 1'b1;
      else if (pop && !wr_en)
        fill_q <= fill_q - 1'b1;
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)
        overflow_q <= 1'b1;
      else if (evt.ovf_clr)
        overflow_q <= 1'b0;
      frame_err_q <= err_set;
      if (err_set && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign evt.evt_data  = mem[rd_ptr];
  assign evt.evt_valid = (fill_q != '0);
  assign evt.fill      = fill_q;
  assign evt.overflow  = overflow_q;
  assign evt.frame_err = frame_err_q;
  assign evt.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - scoreboard bench for ps2_kbd_rx
module tb_ps2_kbd_rx;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [9:0] exp_q[$];

  ps2_kbd_rx_if #(.FIFO_DEPTH(DEPTH)) evt_if ();

  ps2_kbd_rx #(
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .evt(evt_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++)
      ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    wait_cyc(20);
  endtask

  // Monitor: every accepted pop is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: got %0h expected no event", evt_if.evt_data);
      end else begin
        check("evt_data", int'(evt_if.evt_data), int'(exp_q.pop_front()));
      end
    end
    if (!rst && evt_if.frame_err)
      err_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    evt_if.evt_ready = 1'b0;
    evt_if.ovf_clr = 1'b0;
    wait_cyc(5);
    check("rst_valid", int'(evt_if.evt_valid), 0);
    check("rst_fill", int'(evt_if.fill), 0);
    check("rst_ovf", int'(evt_if.overflow), 0);
    check("rst_ferr", int'(evt_if.frame_err), 0);
    check("rst_errcnt", int'(evt_if.err_cnt), 0);
    rst = 1'b0;
    wait_cyc(5);

    // Make code held, then popped.
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0);
    check("make_valid", int'(evt_if.evt_valid), 1);
    check("make_data", int'(evt_if.evt_data), 'h01C);
    check("make_fill", int'(evt_if.fill), 1);
    evt_if.evt_ready = 1'b1;
    wait_cyc(1);
    evt_if.evt_ready = 1'b0;
    check("make_fill_after_pop", int'(evt_if.fill), 0);

    // Break and extended sequences.
    evt_if.evt_ready = 1'b1;
    exp_q.push_back(10'h11C);
    exp_q.push_back(10'h275);
    exp_q.push_back(10'h375);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("seq_left", exp_q.size(), 0);
    check("seq_fill", int'(evt_if.fill), 0);
    evt_if.evt_ready = 1'b0;

    // Overflow: fifth code dropped.
    exp_q.push_back(10'h016);
    exp_q.push_back(10'h01E);
    exp_q.push_back(10'h026);
    exp_q.push_back(10'h025);
    send_frame(8'h16, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'h26, 1'b0);
    check("ovf_pre", int'(evt_if.overflow), 0);
    send_frame(8'h25, 1'b0);
    send_frame(8'h2E, 1'b0);
    check("ovf_fill", int'(evt_if.fill), 4);
    check("ovf_set", int'(evt_if.overflow), 1);
    evt_if.ovf_clr = 1'b1;
    wait_cyc(1);
    evt_if.ovf_clr = 1'b0;
    check("ovf_clr", int'(evt_if.overflow), 0);
    evt_if.evt_ready = 1'b1;
    wait_cyc(10);
    evt_if.evt_ready = 1'b0;
    check("ovf_drain_fill", int'(evt_if.fill), 0);
    check("ovf_drain_left", exp_q.size(), 0);

    // Parity error, then a good frame.
    send_frame(8'h1B, 1'b1);
    check("par_pulses", err_seen, 1);
    check("par_errcnt", int'(evt_if.err_cnt), 1);
    check("par_fill", int'(evt_if.fill), 0);
    exp_q.push_back(10'h01B);
    send_frame(8'h1B, 1'b0);
    check("par_good_fill", int'(evt_if.fill), 1);
    evt_if.evt_ready = 1'b1;
    wait_cyc(2);
    evt_if.evt_ready = 1'b0;
    check("par_left", exp_q.size(), 0);

    // Timeout after 4 data bits.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++)
      ps2_bit(1'b1);
    wait_cyc(TIMEOUT + 50);
    check("to_pulses", err_seen, 2);
    check("to_errcnt", int'(evt_if.err_cnt), 2);
    check("to_fill", int'(evt_if.fill), 0);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0);
    evt_if.evt_ready = 1'b1;
    wait_cyc(2);
    evt_if.evt_ready = 1'b0;
    check("to_left", exp_q.size(), 0);

    // Reset mid-frame with two events queued (not expected to survive).
    send_frame(8'h16, 1'b0);
    send_frame(8'h1E, 1'b0);
    check("rst2_prefill", int'(evt_if.fill), 2);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst2_fill", int'(evt_if.fill), 0);
    check("rst2_valid", int'(evt_if.evt_valid), 0);
    check("rst2_errcnt", int'(evt_if.err_cnt), 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0);
    check("rst2_post_fill", int'(evt_if.fill), 1);
    evt_if.evt_ready = 1'b1;
    wait_cyc(2);
    evt_if.evt_ready = 1'b0;
    check("rst2_left", exp_q.size(), 0);
    check("final_pulses", err_seen, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
